// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris display datapath: FSM encodings,
// digit count and the default converter sizing.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DIGITS      = 4;
  localparam int BIN_W_DEF   = 14;
  localparam int MAX_VAL_DEF = 9999;

endpackage

// File: rtl/score_bcd_conv_if.sv
// Request/result bundle between the score logic (master) and the BCD converter (slave).
// Handshake: start is a one-cycle request, accepted only while the converter is idle
// (busy=0 or done=1); done pulses once when bcd3..bcd0/ovf hold the new result.
interface score_bcd_conv_if #(
  parameter int BIN_W = tetris_pkg::BIN_W_DEF
);
  import tetris_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       bcd3;
  logic [3:0]       bcd2;
  logic [3:0]       bcd1;
  logic [3:0]       bcd0;
  state_e           state;

  modport master (
    output start, bin,
    input  busy, done, ovf, bcd3, bcd2, bcd1, bcd0, state
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, bcd3, bcd2, bcd1, bcd0, state
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/score_bcd_conv.sv
// Iterative binary-to-BCD converter (one bit per clock) feeding the
// seven-segment scan controller; digits hold until a conversion completes.
module score_bcd_conv
  import tetris_pkg::*;
#(
  parameter int BIN_W   = BIN_W_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input logic              clk,
  input logic              rst,
  score_bcd_conv_if.slave  bus
);

  localparam int               CNT_W   = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  state_e                  state_q, state_d;
  logic [4*DIGITS-1:0]     scratch_q;
  logic [4*DIGITS-1:0]     scratch_adj;
  logic [BIN_W-1:0]        bin_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ovf_pend_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[4*d +: 4]),
      .dout (scratch_adj[4*d +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scratch_q  <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.bcd3   <= 4'd0;
      bus.bcd2   <= 4'd0;
      bus.bcd1   <= 4'd0;
      bus.bcd0   <= 4'd0;
    end else begin
      state_q  <= state_d;
      bus.busy <= (state_d != IDLE);
      bus.done <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Saturate so the 16-bit scratch register can never overflow.
            bin_q      <= (bus.bin > MAX_BIN) ? MAX_BIN : bus.bin;
            ovf_pend_q <= (bus.bin > MAX_BIN);
            scratch_q  <= '0;
            cnt_q      <= CNT_W'(BIN_W - 1);
          end
        end
        SHIFT: begin
          {scratch_q, bin_q} <= {scratch_adj, bin_q} << 1;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          bus.bcd3 <= scratch_q[15:12];
          bus.bcd2 <= scratch_q[11:8];
          bus.bcd1 <= scratch_q[7:4];
          bus.bcd0 <= scratch_q[3:0];
          bus.ovf  <= ovf_pend_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_score_bcd_conv.sv
// Directed and randomized bench for score_bcd_conv against a decimal-split reference.
module tb_score_bcd_conv;
  import tetris_pkg::*;

  localparam int BIN_W = 14;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [15:0] prev_d;
  logic        prev_o;

  score_bcd_conv_if #(.BIN_W(BIN_W)) bus ();

  score_bcd_conv #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Reference: saturate, then split into decimal digits.
  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion; optional noise pulses start (bin=777) at E5 and E10.
  task automatic convert(input int value, input bit noise);
    logic [15:0] exp_d;
    logic        exp_o;
    int          lat;
    int          busy_n;
    exp_d = ref_bcd(value);
    exp_o = (value > 9999);
    bus.start = 1'b1;
    bus.bin   = BIN_W'(value);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_rise", {31'd0, bus.busy}, 32'd1);
    chk("done_low_e0", {31'd0, bus.done}, 32'd0);
    busy_n = 1;
    lat    = 0;
    for (int k = 1; k <= 40; k++) begin
      if (noise) begin
        bus.start = (k == 4 || k == 9);
        bus.bin   = BIN_W'(777);
      end
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
      chk("hold_digits", {16'd0, digits()}, {16'd0, prev_d});
      chk("hold_ovf", {31'd0, bus.ovf}, {31'd0, prev_o});
    end
    bus.start = 1'b0;
    chk("latency", lat, 15);
    chk("busy_cycles", busy_n, 15);
    chk("busy_fall", {31'd0, bus.busy}, 32'd0);
    chk("digits", {16'd0, digits()}, {16'd0, exp_d});
    chk("ovf", {31'd0, bus.ovf}, {31'd0, exp_o});
    prev_d = exp_d;
    prev_o = exp_o;
  endtask

  initial begin
    int dones;
    int v;
    int boundary[8];
    vectors     = 0;
    miscompares = 0;
    prev_d      = 16'd0;
    prev_o      = 1'b0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.bin     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_digits", {16'd0, digits()}, 32'd0);
    chk("rst_state", {30'd0, bus.state}, {30'd0, IDLE});
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed values, including back-to-back starts in the done cycle.
    convert(0, 1'b0);
    convert(1234, 1'b0);
    convert(9999, 1'b0);
    convert(10000, 1'b0);
    convert(16383, 1'b0);
    convert(42, 1'b1);
    chk("noise_state", {30'd0, bus.state}, {30'd0, IDLE});
    convert(777, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);

    // Reset in the middle of a conversion.
    bus.start = 1'b1;
    bus.bin   = BIN_W'(5678);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_digits", {16'd0, digits()}, 32'd0);
    chk("midrst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("midrst_state", {30'd0, bus.state}, {30'd0, IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    chk("midrst_no_done", dones, 0);
    chk("midrst_idle_busy", {31'd0, bus.busy}, 32'd0);
    prev_d = 16'd0;
    prev_o = 1'b0;
    convert(5678, 1'b0);

    // Add-3 boundaries and saturation edges.
    boundary = '{5, 50, 500, 5000, 9998, 10001, 4, 99};
    foreach (boundary[i]) convert(boundary[i], 1'b0);

    // Random sweep with occasional idle gaps.
    for (int n = 0; n < 40; n++) begin
      v = $urandom_range(0, 16383);
      convert(v, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
